// File: rtl/model_scoreboard.sv
// -----------------------------------------------------------------------------
// model_scoreboard
//
// In-order scoreboard between the golden reference model (GRM) and the DUT.
// GRM writeback transactions are queued in a DEPTH-entry FIFO and retired
// against DUT writeback transactions as they arrive, so the DUT may lag the
// GRM by up to DEPTH instructions. Errors are reported as a registered pulse,
// a sticky flag, a cause code and saturating counters.
//
// Optional feature macro: MODEL_SCOREBOARD_TIMEOUT_EN
//   defined   -> head-of-queue stall watchdog, raises code 4 every TIMEOUT
//                stalled cycles
//   undefined -> no watchdog logic, code 4 never produced
//
// Parameters:
//   XLEN    width of rd data
//   DEPTH   GRM queue entries (power of two, >= 2)
//   TIMEOUT maximum cycles the queue head may wait for a DUT output
//   CNT_W   width of the statistics counters
//
// Ports:
//   g_clk, g_resetn           clock, synchronous active-low reset
//   g_clk_req                 high while queue non-empty or any valid high
//   grm_out_valid, grm_*      GRM writeback transaction (push side)
//   dut_out_valid, dut_*      DUT writeback transaction (pop/compare side)
//   err_pulse                 one-cycle error indication
//   err_code                  0 none, 1 mismatch, 2 underflow, 3 overflow,
//                             4 timeout; holds until the next error
//   err_sticky                set on first error, cleared only by reset
//   busy                      queue non-empty (registered)
//   n_checked, n_errors       saturating compare / error counters
// -----------------------------------------------------------------------------
module model_scoreboard #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    output logic             g_clk_req,
    input  logic             grm_out_valid,
    input  logic [2:0]       grm_result,
    input  logic             grm_rd_wen,
    input  logic [4:0]       grm_rd_addr,
    input  logic [XLEN-1:0]  grm_rd_data,
    input  logic             dut_out_valid,
    input  logic [2:0]       dut_result,
    input  logic             dut_rd_wen,
    input  logic [4:0]       dut_rd_addr,
    input  logic [XLEN-1:0]  dut_rd_data,
    output logic             err_pulse,
    output logic [2:0]       err_code,
    output logic             err_sticky,
    output logic             busy,
    output logic [CNT_W-1:0] n_checked,
    output logic [CNT_W-1:0] n_errors
);

    localparam int PTR_W = $clog2(DEPTH);
    // Entry layout: {result[2:0], rd_wen, rd_addr[4:0], rd_data[XLEN-1:0]}
    localparam int ENT_W = XLEN + 9;

    localparam logic [PTR_W:0]   PTR_INC  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INC  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_MISMATCH  = 3'd1;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

    // Reject illegal configurations at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 32'sd1)) != 0) || (TIMEOUT < 2)) begin : g_bad_param
        $error("model_scoreboard: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    // Compare an expected entry with a DUT entry. Case equality makes any X/Z
    // on a compared DUT field a mismatch; address and data only matter when
    // the expected transaction actually writes a register.
    function automatic logic entry_match(input logic [ENT_W-1:0] exp_e,
                                         input logic [ENT_W-1:0] dut_e);
        logic ctrl_ok;
        logic wb_ok;
        ctrl_ok = (exp_e[ENT_W-1 -: 4] === dut_e[ENT_W-1 -: 4]);
        wb_ok   = (exp_e[XLEN+4:0] === dut_e[XLEN+4:0]);
        return ctrl_ok && (!exp_e[XLEN+5] || wb_ok);
    endfunction

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             busy_r;
    logic             err_pulse_r;
    logic [2:0]       err_code_r;
    logic             err_sticky_r;
    logic [CNT_W-1:0] n_checked_r;
    logic [CNT_W-1:0] n_errors_r;

    logic [ENT_W-1:0] grm_ent_s;
    logic [ENT_W-1:0] dut_ent_s;
    logic [ENT_W-1:0] head_ent_s;
    logic             empty_s;
    logic             full_s;
    logic             bypass_s;
    logic             pop_s;
    logic             push_s;
    logic             compare_s;
    logic             underflow_s;
    logic             overflow_s;
    logic             mismatch_s;
    logic             timeout_s;
    logic             err_any_s;
    logic [2:0]       err_code_s;
    logic [PTR_W:0]   wr_ptr_nxt_s;
    logic [PTR_W:0]   rd_ptr_nxt_s;

`ifdef MODEL_SCOREBOARD_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_INC  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 32'sd1);

    logic [TO_W-1:0] to_cnt_r;
`endif

    // Queue status, push/pop decisions, compare and error classification.
    always_comb begin
        grm_ent_s    = {grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data};
        dut_ent_s    = {dut_result, dut_rd_wen, dut_rd_addr, dut_rd_data};
        head_ent_s   = mem_r[rd_ptr_r[PTR_W-1:0]];
        empty_s      = (wr_ptr_r == rd_ptr_r);
        // Same slot, different lap bit -> writer is a full lap ahead.
        full_s       = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
        // With an empty queue a same-cycle GRM/DUT pair is checked directly.
        bypass_s     = empty_s && grm_out_valid && dut_out_valid;
        pop_s        = dut_out_valid && !empty_s;
        underflow_s  = dut_out_valid && empty_s && !grm_out_valid;
        // A pop in the same cycle frees the slot, so full+pop+push is legal.
        overflow_s   = grm_out_valid && full_s && !pop_s;
        push_s       = grm_out_valid && !bypass_s && !overflow_s;
        compare_s    = bypass_s || pop_s;
        mismatch_s   = 1'b0;
        timeout_s    = 1'b0;
        err_code_s   = ERR_NONE;

        if (bypass_s) begin
            mismatch_s = !entry_match(grm_ent_s, dut_ent_s);
        end else if (pop_s) begin
            mismatch_s = !entry_match(head_ent_s, dut_ent_s);
        end else begin
            mismatch_s = 1'b0;
        end

`ifdef MODEL_SCOREBOARD_TIMEOUT_EN
        timeout_s = !empty_s && !pop_s && (to_cnt_r == TO_LAST);
`else
        timeout_s = 1'b0;
`endif

        err_any_s = overflow_s || underflow_s || timeout_s || mismatch_s;

        if (overflow_s) begin
            err_code_s = ERR_OVERFLOW;
        end else if (underflow_s) begin
            err_code_s = ERR_UNDERFLOW;
        end else if (timeout_s) begin
            err_code_s = ERR_TIMEOUT;
        end else if (mismatch_s) begin
            err_code_s = ERR_MISMATCH;
        end else begin
            err_code_s = ERR_NONE;
        end

        wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_INC) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + PTR_INC) : rd_ptr_r;
    end

    // Queue storage; contents need no reset because the pointers define validity.
    always_ff @(posedge g_clk) begin
        if (g_resetn && push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= grm_ent_s;
        end
    end

    // Pointers, status and error reporting registers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr_r     <= {(PTR_W+1){1'b0}};
            rd_ptr_r     <= {(PTR_W+1){1'b0}};
            busy_r       <= 1'b0;
            err_pulse_r  <= 1'b0;
            err_code_r   <= ERR_NONE;
            err_sticky_r <= 1'b0;
            n_checked_r  <= {CNT_W{1'b0}};
            n_errors_r   <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            busy_r       <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            err_pulse_r  <= err_any_s;
            err_sticky_r <= err_sticky_r | err_any_s;
            if (err_any_s) begin
                err_code_r <= err_code_s;
            end
            if (compare_s && (n_checked_r != CNT_MAX)) begin
                n_checked_r <= n_checked_r + CNT_INC;
            end
            // At most one error count per cycle, however many causes fired.
            if (err_any_s && (n_errors_r != CNT_MAX)) begin
                n_errors_r <= n_errors_r + CNT_INC;
            end
        end
    end

`ifdef MODEL_SCOREBOARD_TIMEOUT_EN
    // Head-of-queue stall counter; restarts after each timeout so the entry
    // keeps reporting once per TIMEOUT stalled cycles.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            to_cnt_r <= TO_ZERO;
        end else if (empty_s || pop_s || timeout_s) begin
            to_cnt_r <= TO_ZERO;
        end else begin
            to_cnt_r <= to_cnt_r + TO_INC;
        end
    end
`endif

    assign g_clk_req  = busy_r || grm_out_valid || dut_out_valid;
    assign busy       = busy_r;
    assign err_pulse  = err_pulse_r;
    assign err_code   = err_code_r;
    assign err_sticky = err_sticky_r;
    assign n_checked  = n_checked_r;
    assign n_errors   = n_errors_r;

endmodule

// File: tb/tb_model_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_model_scoreboard
//
// Self-checking bench for model_scoreboard (DEPTH=4, TIMEOUT=8). Directed
// table vectors and hand sequences check spec-derived constants; a random
// phase checks every output each cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_model_scoreboard;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [2:0]  res;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic       gv;
        ent_t       g;
        logic       dv;
        ent_t       d;
        logic       e_pulse;
        logic [2:0] e_code;
        logic       e_sticky;
        logic       e_busy;
        int         e_chk;
        int         e_err;
    } vec_t;

    logic             g_clk = 1'b0;
    logic             g_resetn;
    logic             g_clk_req;
    logic             grm_out_valid;
    logic [2:0]       grm_result;
    logic             grm_rd_wen;
    logic [4:0]       grm_rd_addr;
    logic [XLEN-1:0]  grm_rd_data;
    logic             dut_out_valid;
    logic [2:0]       dut_result;
    logic             dut_rd_wen;
    logic [4:0]       dut_rd_addr;
    logic [XLEN-1:0]  dut_rd_data;
    logic             err_pulse;
    logic [2:0]       err_code;
    logic             err_sticky;
    logic             busy;
    logic [CNT_W-1:0] n_checked;
    logic [CNT_W-1:0] n_errors;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    ent_t       mq[$];
    int         m_chk;
    int         m_err;
    int         m_stall;
    logic       m_pulse;
    logic [2:0] m_code;
    logic       m_sticky;

    vec_t vecs[16];

    always #5 g_clk = ~g_clk;

    model_scoreboard #(
        .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .g_clk_req(g_clk_req),
        .grm_out_valid(grm_out_valid), .grm_result(grm_result),
        .grm_rd_wen(grm_rd_wen), .grm_rd_addr(grm_rd_addr), .grm_rd_data(grm_rd_data),
        .dut_out_valid(dut_out_valid), .dut_result(dut_result),
        .dut_rd_wen(dut_rd_wen), .dut_rd_addr(dut_rd_addr), .dut_rd_data(dut_rd_data),
        .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky),
        .busy(busy), .n_checked(n_checked), .n_errors(n_errors)
    );

    function automatic logic ent_ok(input ent_t e, input ent_t d);
        if (e.res !== d.res || e.wen !== d.wen) return 1'b0;
        if (e.wen && (e.addr !== d.addr || e.data !== d.data)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic gv, input ent_t g, input logic dv, input ent_t d);
        grm_out_valid = gv;
        {grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data} = g;
        dut_out_valid = dv;
        {dut_result, dut_rd_wen, dut_rd_addr, dut_rd_data} = d;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0);
    endtask

    // Reference model: advance one clock edge from the inputs seen at that edge.
    task automatic model_step();
        ent_t g, d;
        bit   was_empty, popped, ov, un, to, mm, any;
        g = {grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data};
        d = {dut_result, dut_rd_wen, dut_rd_addr, dut_rd_data};
        if (!g_resetn) begin
            mq.delete();
            m_chk = 0; m_err = 0; m_stall = 0;
            m_pulse = 1'b0; m_code = 3'd0; m_sticky = 1'b0;
            return;
        end
        was_empty = (mq.size() == 0);
        popped = 0; ov = 0; un = 0; to = 0; mm = 0;
        if (dut_out_valid) begin
            if (!was_empty) begin
                mm = !ent_ok(mq[0], d);
                void'(mq.pop_front());
                popped = 1;
                m_chk = sat_inc(m_chk);
            end else if (grm_out_valid) begin
                mm = !ent_ok(g, d);
                m_chk = sat_inc(m_chk);
            end else begin
                un = 1;
            end
        end
        if (grm_out_valid && !(was_empty && dut_out_valid)) begin
            if (mq.size() >= DEPTH) ov = 1;
            else mq.push_back(g);
        end
`ifdef MODEL_SCOREBOARD_TIMEOUT_EN
        if (was_empty || popped) begin
            m_stall = 0;
        end else begin
            m_stall++;
            if (m_stall == TIMEOUT) begin
                to = 1;
                m_stall = 0;
            end
        end
`endif
        any = ov || un || to || mm;
        m_pulse = any;
        if (ov)      m_code = 3'd3;
        else if (un) m_code = 3'd2;
        else if (to) m_code = 3'd4;
        else if (mm) m_code = 3'd1;
        m_sticky = m_sticky | any;
        if (any) m_err = sat_inc(m_err);
    endtask

    task automatic tick();
        @(posedge g_clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        g_resetn = 1'b0;
        idle();
        tick();
        g_resetn = 1'b1;
    endtask

    task automatic check_model();
        check("m_pulse",   32'(err_pulse),  32'(m_pulse));
        check("m_code",    32'(err_code),   32'(m_code));
        check("m_sticky",  32'(err_sticky), 32'(m_sticky));
        check("m_busy",    32'(busy),       32'(mq.size() != 0));
        check("m_checked", 32'(n_checked),  32'(m_chk));
        check("m_errors",  32'(n_errors),   32'(m_err));
        check("m_clk_req", 32'(g_clk_req),
              32'((mq.size() != 0) || grm_out_valid || dut_out_valid));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulse"},   32'(err_pulse),  32'd0);
        check({tag, "_code"},    32'(err_code),   32'd0);
        check({tag, "_sticky"},  32'(err_sticky), 32'd0);
        check({tag, "_busy"},    32'(busy),       32'd0);
        check({tag, "_checked"}, 32'(n_checked),  32'd0);
        check({tag, "_errors"},  32'(n_errors),   32'd0);
    endtask

    initial begin
        ent_t e;
        // {gv, g{res,wen,addr,data}, dv, d{...}, pulse, code, sticky, busy, chk, err}
        vecs[0]  = '{1'b1, '{3'd0,1'b1,5'd1,32'h11}, 1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0,3'd0,1'b0,1'b1, 0,0};
        vecs[1]  = '{1'b1, '{3'd0,1'b1,5'd2,32'h22}, 1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0,3'd0,1'b0,1'b1, 0,0};
        vecs[2]  = '{1'b1, '{3'd0,1'b1,5'd3,32'h33}, 1'b1, '{3'd0,1'b1,5'd1,32'h11}, 1'b0,3'd0,1'b0,1'b1, 1,0};
        vecs[3]  = '{1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b1, '{3'd0,1'b1,5'd2,32'h22}, 1'b0,3'd0,1'b0,1'b1, 2,0};
        vecs[4]  = '{1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b1, '{3'd0,1'b1,5'd3,32'h33}, 1'b0,3'd0,1'b0,1'b0, 3,0};
        vecs[5]  = '{1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0,3'd0,1'b0,1'b0, 3,0};
        vecs[6]  = '{1'b1, '{3'd2,1'b1,5'd4,32'h33}, 1'b1, '{3'd2,1'b1,5'd4,32'h33}, 1'b0,3'd0,1'b0,1'b0, 4,0};
        vecs[7]  = '{1'b1, '{3'd2,1'b1,5'd4,32'h33}, 1'b1, '{3'd2,1'b1,5'd4,32'h34}, 1'b1,3'd1,1'b1,1'b0, 5,1};
        vecs[8]  = '{1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0,3'd1,1'b1,1'b0, 5,1};
        vecs[9]  = '{1'b1, '{3'd1,1'b0,5'd5,32'hAA}, 1'b1, '{3'd1,1'b0,5'd6,32'h55}, 1'b0,3'd1,1'b1,1'b0, 6,1};
        vecs[10] = '{1'b1, '{3'd3,1'b0,5'd7,32'h1},  1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0,3'd1,1'b1,1'b1, 6,1};
        vecs[11] = '{1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b1, '{3'd3,1'b0,5'd9,32'h2},  1'b0,3'd1,1'b1,1'b0, 7,1};
        vecs[12] = '{1'b1, '{3'd1,1'b0,5'd0,32'h0},  1'b1, '{3'd5,1'b0,5'd0,32'h0},  1'b1,3'd1,1'b1,1'b0, 8,2};
        vecs[13] = '{1'b1, '{3'd0,1'b1,5'd8,32'h77}, 1'b1, '{3'd0,1'b0,5'd8,32'h77}, 1'b1,3'd1,1'b1,1'b0, 9,3};
        vecs[14] = '{1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b1, '{3'd0,1'b0,5'd0,32'h0},  1'b1,3'd2,1'b1,1'b0, 9,4};
        vecs[15] = '{1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0, '{3'd0,1'b0,5'd0,32'h0},  1'b0,3'd2,1'b1,1'b0, 9,4};

        // Reset state
        g_resetn = 1'b0;
        idle();
        tick();
        tick();
        g_resetn = 1'b1;
        check_zero("reset");
        check("reset_clk_req", 32'(g_clk_req), 32'd0);

        // Table-driven directed vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].gv, vecs[i].g, vecs[i].dv, vecs[i].d);
            tick();
            check($sformatf("vec%0d_pulse", i),   32'(err_pulse),  32'(vecs[i].e_pulse));
            check($sformatf("vec%0d_code", i),    32'(err_code),   32'(vecs[i].e_code));
            check($sformatf("vec%0d_sticky", i),  32'(err_sticky), 32'(vecs[i].e_sticky));
            check($sformatf("vec%0d_busy", i),    32'(busy),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d_checked", i), 32'(n_checked),  32'(vecs[i].e_chk));
            check($sformatf("vec%0d_errors", i),  32'(n_errors),   32'(vecs[i].e_err));
            check($sformatf("vec%0d_clk_req", i), 32'(g_clk_req),
                  32'(vecs[i].e_busy || vecs[i].gv || vecs[i].dv));
        end

        // Overflow: 5 pushes into a 4-deep queue, then full push+pop is legal
        do_reset();
        check_zero("rst2");
        for (int k = 1; k <= 5; k++) begin
            e = '{3'd0, 1'b1, 5'(k), 32'(k)};
            drive(1'b1, e, 1'b0, '0);
            tick();
            check($sformatf("ovf_push%0d_pulse", k), 32'(err_pulse), 32'(k == 5));
            check($sformatf("ovf_push%0d_busy", k),  32'(busy),      32'd1);
        end
        check("ovf_code",   32'(err_code), 32'd3);
        check("ovf_errors", 32'(n_errors), 32'd1);
        drive(1'b1, '{3'd0, 1'b1, 5'd6, 32'd6}, 1'b1, '{3'd0, 1'b1, 5'd1, 32'd1});
        tick();
        check("full_pp_pulse",   32'(err_pulse), 32'd0);
        check("full_pp_checked", 32'(n_checked), 32'd1);
        check("full_pp_code",    32'(err_code),  32'd3);
        // Remaining queue must be 2,3,4,6: the dropped push never landed
        for (int k = 0; k < 4; k++) begin
            int v;
            v = (k == 3) ? 6 : k + 2;
            drive(1'b0, '0, 1'b1, '{3'd0, 1'b1, 5'(v), 32'(v)});
            tick();
            check($sformatf("drain%0d_pulse", k), 32'(err_pulse), 32'd0);
        end
        idle();
        check("drain_busy",    32'(busy),      32'd0);
        check("drain_checked", 32'(n_checked), 32'd5);
        check("drain_errors",  32'(n_errors),  32'd1);

        // Underflow from a fresh reset
        do_reset();
        drive(1'b0, '0, 1'b1, '{3'd1, 1'b1, 5'd2, 32'h9});
        tick();
        check("udf_pulse",   32'(err_pulse), 32'd1);
        check("udf_code",    32'(err_code),  32'd2);
        check("udf_checked", 32'(n_checked), 32'd0);
        check("udf_errors",  32'(n_errors),  32'd1);
        check("udf_busy",    32'(busy),      32'd0);

        // Head stall: one push, no DUT output
        do_reset();
        drive(1'b1, '{3'd0, 1'b1, 5'd1, 32'h5}, 1'b0, '0);
        tick();
        idle();
        for (int i = 1; i <= 24; i++) begin
            tick();
`ifdef MODEL_SCOREBOARD_TIMEOUT_EN
            check($sformatf("stall%0d_pulse", i), 32'(err_pulse), 32'((i % 8) == 0));
`else
            check($sformatf("stall%0d_pulse", i), 32'(err_pulse), 32'd0);
`endif
            check($sformatf("stall%0d_busy", i), 32'(busy), 32'd1);
        end
`ifdef MODEL_SCOREBOARD_TIMEOUT_EN
        check("to_code",   32'(err_code), 32'd4);
        check("to_errors", 32'(n_errors), 32'd3);
`else
        check("noto_code", 32'(err_code), 32'd0);
`endif
        // Reset mid-stall with a GRM push presented on the reset edge
        tick();
        tick();
        g_resetn = 1'b0;
        drive(1'b1, '{3'd0, 1'b1, 5'd3, 32'h7}, 1'b0, '0);
        tick();
        check_zero("midrst");
        g_resetn = 1'b1;
        idle();
        tick();
        check_zero("postrst");
        check("postrst_clk_req", 32'(g_clk_req), 32'd0);

        // Randomized phase against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            ent_t ge, de;
            logic gv, dv;
            gv = ($urandom_range(0, 99) < 50);
            dv = ($urandom_range(0, 99) < 45);
            ge.res  = 3'($urandom_range(0, 7));
            ge.wen  = 1'($urandom_range(0, 1));
            ge.addr = 5'($urandom_range(0, 31));
            ge.data = 32'($urandom);
            if (mq.size() != 0) begin
                de = mq[0];
            end else if (gv) begin
                de = ge;
            end else begin
                de = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), 32'($urandom)};
            end
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       de.data = de.data ^ 32'h1;
                    1:       de.res  = de.res ^ 3'h1;
                    default: de.addr = de.addr ^ 5'h1;
                endcase
            end
            drive(gv, ge, dv, de);
            tick();
            check_model();
        end

        idle();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/model_scoreboard.md
# model_scoreboard

Parametrised in-order scoreboard that replaces the lock-step output check in the co-processor verification environment. Golden-reference-model (GRM) writeback transactions are queued in a DEPTH-entry FIFO and retired against DUT writeback transactions as they arrive, so the DUT may lag the GRM by up to DEPTH instructions. Detected errors are reported as registered pulses, a sticky flag, an error code and counters. The scoreboard sits beside the DUT and GRM in the simulation and formal testbenches.

## Interface
- XLEN, 32, width of rd data.
- DEPTH, 4, GRM queue entries; must be a power of two, minimum 2.
- TIMEOUT, 64, maximum cycles the queue head may wait for a DUT output.
- CNT_W, 16, width of the statistics counters.

- g_clk  in  1  global clock.
- g_resetn  in  1  reset; synchronous, active-low.
- g_clk_req  out  1  clock request; high while the queue is non-empty or any input valid is high.
- grm_out_valid  in  1  GRM writeback valid.
- grm_result  in  3  GRM execution result.
- grm_rd_wen  in  1  GRM GPR write enable.
- grm_rd_addr  in  5  GRM GPR address.
- grm_rd_data  in  XLEN  GRM GPR data.
- dut_out_valid  in  1  DUT writeback valid.
- dut_result  in  3  DUT execution result.
- dut_rd_wen  in  1  DUT GPR write enable.
- dut_rd_addr  in  5  DUT GPR address.
- dut_rd_data  in  XLEN  DUT GPR data.
- err_pulse  out  1  one-cycle error indication.
- err_code  out  3  cause of the last error: 0 none, 1 mismatch, 2 underflow, 3 overflow, 4 timeout.
- err_sticky  out  1  set on the first error; cleared only by reset.
- busy  out  1  queue non-empty.
- n_checked  out  CNT_W  number of DUT transactions compared.
- n_errors  out  CNT_W  number of errors.

## Operation
- **Queue entry.** Each entry holds {result, rd_wen, rd_addr, rd_data}. Read and write pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. Pointers wrap naturally.
- **Push.** When grm_out_valid is high, the GRM fields are written at the write pointer.
- **Pop/compare.** When dut_out_valid is high, the DUT fields are compared with the head entry and the head is popped.
  - **Bypass.** If the queue is empty and both valids are high in the same cycle, the DUT is compared directly against the GRM inputs. Nothing is pushed and the queue stays empty.
- **Match rule.** result and rd_wen must be equal. rd_addr and rd_data are compared only when the expected rd_wen is 1. Any X or Z on a compared DUT field counts as a mismatch (case-equality semantics).
- **Underflow.** dut_out_valid with the queue empty and no simultaneous GRM valid. No pop occurs; the event counts as an error, not as a check.
- **Overflow.** grm_out_valid while the queue is full and there is no simultaneous pop. The push is dropped. A simultaneous push and pop when full is legal.
- **Error priority.** When several errors occur in one cycle, the reported code is taken in this order: overflow > underflow > timeout > mismatch. n_errors increments by 1 per cycle regardless of how many errors occurred.
- **Counters.** n_checked counts every compare, including bypass compares. Both counters saturate at all-ones.

## Timing
- Reset state: pointers 0; err_pulse 0; err_code 0; err_sticky 0; n_checked 0; n_errors 0; timeout counter 0. busy and g_clk_req are 0 once the reset edge has been taken.
- Latency: err_pulse, err_code and the counters update on the clock edge that samples the offending input, i.e. they are visible one cycle after the transaction. err_code holds its value until the next error.
- Throughput: one push and one pop per cycle.
- busy is registered and reflects the post-edge pointers.
- Reset asserted mid-operation flushes the queue and clears all state at that edge. Inputs sampled on the reset edge are ignored.

## Configuration
- **MODEL_SCOREBOARD_TIMEOUT_EN defined:**
  - A counter runs while the queue is non-empty and no pop occurs.
  - It clears on every pop and whenever the queue is empty.
  - When the counter reaches TIMEOUT, a timeout error (code 4) is raised once. The counter then clears and the entry stays queued.
- **MODEL_SCOREBOARD_TIMEOUT_EN undefined:** the counter logic is absent and code 4 is never produced.

## Test plan
- GRM pushes 3 entries (data 0x11, 0x22, 0x33, wen 1); the DUT returns identical entries 2 cycles later → n_checked=3, n_errors=0, busy=0 at the end.
- Bypass: both valids high with the queue empty, identical fields → n_checked=1, busy stays 0. The same test with dut_rd_data=0x34 vs 0x33 → err_pulse for 1 cycle, err_code=1, err_sticky=1.
- rd_wen=0 on both sides with different rd_addr and rd_data → no error.
- DEPTH=4: 5 GRM pushes with no DUT output → 5th push gives err_code=3 and the queue keeps 4 entries. Then push and pop in the same cycle while full → no error.
- DUT valid with the queue empty → err_code=2, n_checked unchanged, n_errors=1.
- With MODEL_SCOREBOARD_TIMEOUT_EN and TIMEOUT=8: 1 push, no DUT output → err_code=4 exactly once per 8 stalled cycles. Reset asserted mid-stall → all outputs return to 0 and busy=0.
